// File: rtl/mem_stream_loader.sv
// rtl/mem_stream_loader.sv - packs a byte stream into 32-bit RAM words, then reads them back to verify a checksum
module mem_stream_loader #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        lane;
  logic [3:0]        be, last_be;
  logic [31:0]       wdata, rsum, rsum_nxt, cap_data, last_mask;
  logic              last_flag;
  logic [ADDR_W:0]   rd_addr;
  logic              cap_valid, cap_last, issue, accept;

  always_comb begin
    accept    = (state == LOAD) && in_valid;
    issue     = (state == VERIFY) && (rd_addr < word_count);
    last_mask = {{8{last_be[3]}}, {8{last_be[2]}}, {8{last_be[1]}}, {8{last_be[0]}}};
    // only the final word of the stream may hold unwritten lanes
    cap_data  = cap_last ? (mem_readdata & last_mask) : mem_readdata;
    rsum_nxt  = rsum + cap_data;

    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       if (accept && (lane == 2'd3 || in_last)) state_nxt = WRITE;
      WRITE: begin
        if (last_flag)                              state_nxt = VERIFY;
        else if (addr == ADDR_W'(MEM_WORDS - 1))    state_nxt = DONE;
        else                                        state_nxt = LOAD;
      end
      VERIFY:     if (cap_valid && cap_last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase

    in_ready       = (state == LOAD);
    busy           = (state == LOAD) || (state == WRITE) || (state == VERIFY);
    done           = (state == DONE);
    mem_chipselect = (state == WRITE) || issue;
    mem_write      = (state == WRITE);
    mem_address    = '0;
    mem_byteenable = 4'h0;
    mem_writedata  = 32'h0;
    if (state == WRITE) begin
      mem_address    = addr;
      mem_byteenable = be;
      mem_writedata  = wdata;
    end else if (issue) begin
      mem_address    = rd_addr[ADDR_W-1:0];
      mem_byteenable = 4'hF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      lane       <= 2'd0;
      be         <= 4'h0;
      last_be    <= 4'h0;
      wdata      <= 32'h0;
      rsum       <= 32'h0;
      last_flag  <= 1'b0;
      rd_addr    <= '0;
      cap_valid  <= 1'b0;
      cap_last   <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      checksum   <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr       <= '0;
            lane       <= 2'd0;
            be         <= 4'h0;
            wdata      <= 32'h0;
            rsum       <= 32'h0;
            last_flag  <= 1'b0;
            rd_addr    <= '0;
            cap_valid  <= 1'b0;
            cap_last   <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            checksum   <= 32'h0;
          end
        end
        LOAD: begin
          if (accept) begin
            wdata[8*lane +: 8] <= in_data;
            be[lane]           <= 1'b1;
            lane               <= lane + 2'd1;
            last_flag          <= in_last;
          end
        end
        WRITE: begin
          checksum   <= checksum + wdata;
          word_count <= word_count + (ADDR_W+1)'(1);
          addr       <= addr + ADDR_W'(1);
          last_be    <= be;
          lane       <= 2'd0;
          be         <= 4'h0;
          wdata      <= 32'h0;
          rd_addr    <= '0;
          cap_valid  <= 1'b0;
          cap_last   <= 1'b0;
          if (!last_flag && addr == ADDR_W'(MEM_WORDS - 1)) error <= 1'b1;
        end
        VERIFY: begin
          // readdata lags its address by one cycle, so the capture flags trail issue
          rd_addr   <= rd_addr + (ADDR_W+1)'(issue);
          cap_valid <= issue;
          cap_last  <= issue && (rd_addr == word_count - (ADDR_W+1)'(1));
          if (cap_valid) rsum <= rsum_nxt;
          if (cap_valid && cap_last) error <= (rsum_nxt != checksum);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_loader.sv
// tb/tb_mem_stream_loader.sv - directed self-checking bench for mem_stream_loader with a one-cycle-latency RAM model
module tb_mem_stream_loader;

  logic        clk = 1'b0;
  logic        reset_n, start, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
  logic        busy, done, error;
  logic [10:0] word_count;
  logic [31:0] checksum;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram [0:1023];
  logic [9:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  logic [3:0]  wr_be   [$];
  int          rd_count = 0;
  bit          corrupt  = 1'b0;
  bit          fill_req = 1'b0;
  logic [31:0] fill_val = 32'h0;
  logic [7:0]  pat [$];

  always #5 clk = ~clk;

  mem_stream_loader #(.MEM_WORDS(1024), .ADDR_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .busy(busy), .done(done), .error(error),
    .word_count(word_count), .checksum(checksum)
  );

  // RAM model: byte-enabled writes, registered reads, optional bit-0 flip on address 0
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 1024; i++) ram[i] <= fill_val;
    end else if (mem_chipselect && mem_write) begin
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_writedata);
      wr_be.push_back(mem_byteenable);
      for (int k = 0; k < 4; k++)
        if (mem_byteenable[k]) ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
    end
    if (mem_chipselect && !mem_write) begin
      mem_readdata <= ram[mem_address] ^ ((corrupt && mem_address == 10'd0) ? 32'h1 : 32'h0);
      rd_count     <= rd_count + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_ram(input logic [31:0] v);
    @(negedge clk); fill_val = v; fill_req = 1'b1;
    @(negedge clk); fill_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit l, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_pat(input bit with_last, input int gap_max, input int restart_at);
    for (int i = 0; i < pat.size(); i++) begin
      if (i == restart_at) pulse_start();
      send_byte(pat[i], with_last && (i == pat.size() - 1),
                gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 5000) begin @(negedge clk); n++; end
    check(tag, done, 1);
  endtask

  task automatic check_two_words(input string t, input int base,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] b1);
    check({t, "_nwr"},  wr_addr.size() - base, 2);
    check({t, "_a0"},   wr_addr[base],   0);
    check({t, "_d0"},   wr_data[base],   d0);
    check({t, "_b0"},   wr_be[base],     4'hF);
    check({t, "_a1"},   wr_addr[base+1], 1);
    check({t, "_d1"},   wr_data[base+1], d1);
    check({t, "_b1"},   wr_be[base+1],   b1);
  endtask

  initial begin
    int base, rbase, errs;
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0;
    #2;
    check("rst_ctl", {busy, done, error, in_ready, mem_chipselect, mem_write, mem_byteenable, mem_address}, 0);
    check("rst_dat", {word_count, checksum}, 0);
    check("rst_wd",  mem_writedata, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;
    fill_ram(32'h0);

    // reset asserted mid-LOAD with a partial word collected
    pulse_start();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    @(negedge clk); in_valid = 1'b1; in_data = 8'h33;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ctl", {busy, done, error, in_ready, mem_chipselect, mem_write, mem_byteenable}, 0);
    base = wr_addr.size(); rbase = rd_count;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_no_access", (wr_addr.size() - base) + (rd_count - rbase), 0);
    in_valid = 1'b0;

    // two full words
    pat = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    base = wr_addr.size();
    pulse_start();
    send_pat(1'b1, 0, -1);
    wait_done("full_done");
    check_two_words("full", base, 32'h04030201, 32'h08070605, 4'hF);
    check("full_wc",  word_count, 2);
    check("full_sum", checksum, 32'h0C0A0806);
    check("full_err", error, 0);
    check("full_busy", busy, 0);

    // partial final word; RAM holds garbage in the unwritten lanes
    fill_ram(32'hDEADBEEF);
    pat = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    base = wr_addr.size();
    pulse_start();
    send_pat(1'b1, 0, -1);
    wait_done("part_done");
    check_two_words("part", base, 32'hDDCCBBAA, 32'h000000EE, 4'h1);
    check("part_sum", checksum, 32'hDDCCBC98);
    check("part_err", error, 0);

    // corrupted readback of address 0
    corrupt = 1'b1;
    pat = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    pulse_start();
    send_pat(1'b1, 0, -1);
    wait_done("corr_done");
    check("corr_err", error, 1);
    corrupt = 1'b0;

    // overflow: 4096 bytes without last
    pat.delete();
    for (int i = 0; i < 4096; i++) pat.push_back(8'(i));
    base = wr_addr.size(); rbase = rd_count;
    pulse_start();
    send_pat(1'b0, 0, -1);
    wait_done("ovf_done");
    check("ovf_nwr", wr_addr.size() - base, 1024);
    errs = 0;
    for (int i = 0; i < 1024; i++) if (wr_addr[base+i] != 10'(i)) errs++;
    check("ovf_addrs", errs, 0);
    check("ovf_err", error, 1);
    check("ovf_in_ready", in_ready, 0);
    check("ovf_wc", word_count, 1024);
    check("ovf_no_verify", rd_count - rbase, 0);
    @(negedge clk);
    check("ovf_err_hold", error, 1);

    // restart from DONE, random gaps, stray start while busy
    pat = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    base = wr_addr.size();
    pulse_start();
    check("rs_cleared", {done, error, word_count}, 0);
    check("rs_busy", busy, 1);
    send_pat(1'b1, 3, 3);
    wait_done("rs_done");
    check_two_words("rs", base, 32'h04030201, 32'h08070605, 4'hF);
    check("rs_wc",  word_count, 2);
    check("rs_sum", checksum, 32'h0C0A0806);
    check("rs_err", error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
